// File: rtl/regfile_param.sv
// Parametrised register file: two read ports, one byte-strobed write port, optional zero reg/bypass.
// Latency: reads 0 cycles (READ_REG=0) or 1 cycle (READ_REG=1); writes land in the array on the edge.
// Backpressure: none; a write is accepted every cycle and the registered outputs stall only on read_en=0.
module regfile_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit BYPASS     = 1'b1,
    parameter bit READ_REG   = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   read_reg1,
    input  logic [ADDR_WIDTH-1:0]   read_reg2,
    input  logic                    read_en,
    input  logic                    write,
    input  logic [ADDR_WIDTH-1:0]   write_reg,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic [DATA_WIDTH/8-1:0] write_strb,
    output logic [DATA_WIDTH-1:0]   read_data1,
    output logic [DATA_WIDTH-1:0]   read_data2
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  wr_ok;
    logic [ADDR_WIDTH-1:0] raddr [2];
    logic [DATA_WIDTH-1:0] rval  [2];

    // Writes to entry 0 are discarded when it is the hardwired zero register.
    assign wr_ok = write && !(ZERO_REG && (write_reg == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            for (int k = 0; k < NB; k++) begin
                if (write_strb[k]) begin
                    mem[write_reg][8*k +: 8] <= write_data[8*k +: 8];
                end
            end
        end
    end

    assign raddr[0] = read_reg1;
    assign raddr[1] = read_reg2;

    // Bypass is gated by rst_n so a write held during reset never shows on the outputs.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rval[p] = mem[raddr[p]];
            if (BYPASS && rst_n && wr_ok && (write_reg == raddr[p])) begin
                for (int k = 0; k < NB; k++) begin
                    if (write_strb[k]) begin
                        rval[p][8*k +: 8] = write_data[8*k +: 8];
                    end
                end
            end
            if (ZERO_REG && (raddr[p] == '0)) begin
                rval[p] = '0;
            end
        end
    end

    generate
        if (READ_REG) begin : g_rreg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    read_data1 <= '0;
                    read_data2 <= '0;
                end else if (read_en) begin
                    read_data1 <= rval[0];
                    read_data2 <= rval[1];
                end
            end
        end else begin : g_comb
            logic unused_read_en;
            assign unused_read_en = read_en;
            assign read_data1     = rval[0];
            assign read_data2     = rval[1];
        end
    endgenerate

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised general-purpose register file for the RISC-V simple datapath: two read ports, one synchronous write port with byte strobes, an optional hardwired zero register, optional write-to-read bypass, and an optional registered-read mode. It replaces the fixed 32x32 combinational register file. It sits between decode (read addresses) and writeback (write port). All state is held in flops cleared by an asynchronous reset.

## Interface
- DATA_WIDTH, 32, register width in bits; must be a multiple of 8
- ADDR_WIDTH, 5, address width; depth = 2**ADDR_WIDTH
- ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes; 0 = entry 0 is an ordinary register
- BYPASS, 1, 1 = a read of the address being written returns the post-write value; 0 = the read returns the stored (old) value
- READ_REG, 0, 0 = combinational read (latency 0); 1 = registered read outputs (latency 1)

- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- read_reg1  in  ADDR_WIDTH  port 1 read address
- read_reg2  in  ADDR_WIDTH  port 2 read address
- read_en  in  1  READ_REG=1: update both output registers on this edge; ignored when READ_REG=0
- write  in  1  write enable
- write_reg  in  ADDR_WIDTH  write address
- write_data  in  DATA_WIDTH  write data
- write_strb  in  DATA_WIDTH/8  byte enables; bit k enables byte [8k+7:8k]
- read_data1  out  DATA_WIDTH  port 1 read data
- read_data2  out  DATA_WIDTH  port 2 read data

## Operation
- **Storage:** an array of 2**ADDR_WIDTH entries, each DATA_WIDTH bits.
- **Write:** on the rising clk edge with `write`=1, each byte k of entry[write_reg] takes write_data byte k if write_strb[k]=1 and holds otherwise.
  - write_strb = 0 leaves the entry unchanged.
  - write=0 changes nothing.
- **Zero register (ZERO_REG=1):**
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0 on every path, bypass included.
- **Merged value** for address A during a cycle:
  - If write=1, write_reg=A and the write is not dropped: strobe-selected bytes come from write_data, the remaining bytes from entry[A].
  - Otherwise: entry[A].
- **Read value** for port p:
  - BYPASS=1: the merged value of read_reg_p.
  - BYPASS=0: entry[read_reg_p].
- **READ_REG=0:** read_data_p is the read value, combinational from the address, array, and write inputs.
- **READ_REG=1:**
  - On a rising edge with read_en=1, read_data_p registers the read value computed in the cycle before that edge.
  - With read_en=0 the outputs hold.
- **Both ports:** the two ports are independent. Both may address the same entry or the write address in the same cycle, and each resolves independently.

## Timing
- **Reset:** rst_n low asynchronously clears every entry to 0 and, when READ_REG=1, clears read_data1/2 to 0.
  - READ_REG=0 outputs then show 0 after combinational settling.
  - While rst_n is low, no write and no read-register update takes effect on any edge.
- **Reset release:** rst_n deassertion is synchronous to clk (guaranteed externally). The first write can take effect on the first rising edge with rst_n=1.
- **Reset mid-operation:** a write in flight when rst_n falls is lost, and all entries read 0.
- **Write latency:** the written data is visible through the array one cycle after the edge.
  - With BYPASS=1 it is also visible in the same cycle (READ_REG=0) or in the registered output at the same edge (READ_REG=1).
- **Read latency:** READ_REG=0 gives 0 cycles; READ_REG=1 gives 1 cycle.
- **Combinational loops:** none. With READ_REG=0, the path write_data -> read_data exists only when BYPASS=1.

## Test plan
- **Reset:** hold rst_n low, drive write=1, write_reg=3, write_data=0xDEADBEEF, strb=4'hF for 2 edges; release rst_n, then read 3 -> 0x00000000, and read_data=0 during reset.
- **Zero register:** with ZERO_REG=1, write 0xFFFFFFFF to address 0, then read address 0 on both ports -> 0 every cycle, including the same-cycle bypass.
- **Byte strobes:** write 0x11223344 (strb=4'hF) to reg 5, then write 0xAABBCCDD with strb=4'b0101 to reg 5; read 5 -> 0x11BB33DD.
- **Bypass vs. no bypass:** reg 7 holds 0x1; in the same cycle write 0x2 to reg 7 and read reg 7 on both ports.
  - BYPASS=1 -> 0x2 that cycle.
  - BYPASS=0 -> 0x1 that cycle and 0x2 the next cycle.
- **Registered read:** with READ_REG=1, set read_reg1=9 (holding 0x55) and read_en=1 -> read_data1=0x55 after one edge; drop read_en and change reg 9 to 0x66 -> read_data1 stays 0x55 until read_en=1 again.
- **Parametrisation:** with DATA_WIDTH=64, ADDR_WIDTH=3, ZERO_REG=0, write distinct values to all 8 entries including address 0; read back all 8 through both ports -> every value matches.
